alarm_controller: RTL and testbench

Parametrised multi-channel alarm controller for the smart-home automation top level, successor to the fixed three-alarm (fire/burglar/rain) block. Each channel debounces a raw sensor level, latches an alarm until acknowledged, and can be armed or disarmed individually. A priority encoder reports the most urgent active channel for the display and siren logic. An optional escalation timer flags alarms left unacknowledged.

---
 rtl/alarm_pkg.sv | 16 +
 rtl/alarm_channel.sv | 113 +++++++++++
 rtl/alarm_controller.sv | 57 +++++
 tb/tb_alarm_controller.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared types and constants for the multi-channel alarm controller.
package alarm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PENDING = 2'd1,
      ST_ACTIVE  = 2'd2,
      ST_ACKED   = 2'd3
   } state_t;

   // Default channel mapping inherited from the fixed fire/burglar/rain block.
   localparam int CH_FIRE    = 0;
   localparam int CH_BURGLAR = 1;
   localparam int CH_RAIN    = 2;

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: debounce, latch-until-ack, per-channel arming and an
// optional unacknowledged-alarm escalation timer (enabled by the macro
// ALARM_ESCALATE_EN; without it esc is tied low and no counter exists).
module alarm_channel
   import alarm_pkg::*;
#(
   parameter int DEBOUNCE   = 4,
   parameter int ESC_CYCLES = 20
) (
   input  logic clk,
   input  logic reset,
   input  logic sensor,
   input  logic arm,
   input  logic ack,
   output logic alarm,
   output logic esc
);

   localparam int CW = $clog2(DEBOUNCE + 1);
   // Count value at which one more high sample completes the debounce.
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

   // Both parameters must be at least one for the timing to make sense.
   if (DEBOUNCE < 1 || ESC_CYCLES < 1) begin : g_bad_param
      $error("alarm_channel: DEBOUNCE and ESC_CYCLES must be >= 1");
   end

   state_t        state;
   logic [CW-1:0] cnt;

   // Channel FSM with registered alarm output; disarm overrides everything.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
         cnt   <= '0;
         alarm <= 1'b0;
      end else if (!arm) begin
         state <= ST_IDLE;
         cnt   <= '0;
         alarm <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (sensor) begin
                  if (DEBOUNCE == 1) begin
                     state <= ST_ACTIVE;
                     alarm <= 1'b1;
                  end else begin
                     state <= ST_PENDING;
                     cnt   <= CW'(1);
                  end
               end
            end
            ST_PENDING: begin
               if (!sensor) begin
                  state <= ST_IDLE;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state <= ST_ACTIVE;
                  cnt   <= '0;
                  alarm <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_ACTIVE: begin
               // Latched: only an ack releases it. A still-present condition
               // parks in ACKED so it does not immediately re-trigger.
               if (ack) begin
                  state <= sensor ? ST_ACKED : ST_IDLE;
                  alarm <= 1'b0;
               end
            end
            ST_ACKED: begin
               if (!sensor) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
               cnt   <= '0;
               alarm <= 1'b0;
            end
         endcase
      end
   end

`ifdef ALARM_ESCALATE_EN
   localparam int EW = $clog2(ESC_CYCLES + 1);
   localparam logic [EW-1:0] ESC_MAX = EW'(ESC_CYCLES);

   logic [EW-1:0] esc_cnt;

   // Count edges spent ACTIVE without ack; esc is sticky until the alarm is left.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         esc_cnt <= '0;
         esc     <= 1'b0;
      end else if (!arm || ack || state != ST_ACTIVE) begin
         esc_cnt <= '0;
         esc     <= 1'b0;
      end else if (esc_cnt != ESC_MAX) begin
         esc_cnt <= esc_cnt + 1'b1;
         if (esc_cnt == ESC_MAX - 1'b1) begin
            esc <= 1'b1;
         end
      end
   end
`else
   assign esc = 1'b0;
`endif

endmodule

// File: rtl/alarm_controller.sv
// Multi-channel alarm controller: NUM_CH independent channels, OR reduction
// and a lowest-index-wins priority encoder over the registered alarms.
// Optional escalation output is built only with ALARM_ESCALATE_EN defined.
module alarm_controller
   import alarm_pkg::*;
#(
   parameter int NUM_CH     = 3,
   parameter int DEBOUNCE   = 4,
   parameter int ESC_CYCLES = 20
) (
   input  logic                                           clk,
   input  logic                                           reset,
   input  logic [NUM_CH-1:0]                              sensor,
   input  logic [NUM_CH-1:0]                              arm,
   input  logic [NUM_CH-1:0]                              ack,
   output logic [NUM_CH-1:0]                              alarm,
   output logic                                           any_alarm,
   output logic                                           top_valid,
   output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] top_ch,
   output logic                                           escalate
);

   localparam int TW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [NUM_CH-1:0] esc_vec;

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      alarm_channel #(
         .DEBOUNCE   (DEBOUNCE),
         .ESC_CYCLES (ESC_CYCLES)
      ) u_channel (
         .clk    (clk),
         .reset  (reset),
         .sensor (sensor[gi]),
         .arm    (arm[gi]),
         .ack    (ack[gi]),
         .alarm  (alarm[gi]),
         .esc    (esc_vec[gi])
      );
   end

   assign any_alarm = |alarm;
   assign top_valid = any_alarm;
   // Channels tie esc low when escalation is not built, so this is constant 0 then.
   assign escalate  = |esc_vec;

   // Priority encoder: scan from the top so the lowest set index is left last.
   always_comb begin
      top_ch = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (alarm[i]) begin
            top_ch = TW'(i);
         end
      end
   end

endmodule

// File: tb/tb_alarm_controller.sv
// Self-checking bench for alarm_controller with the default 3 channels.
module tb_alarm_controller;

   localparam int NCH = 3;
   localparam int DEB = 4;
   localparam int ESC = 20;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic [NCH-1:0] sensor = '0;
   logic [NCH-1:0] arm = '1;
   logic [NCH-1:0] ack = '0;
   logic [NCH-1:0] alarm;
   logic           any_alarm;
   logic           top_valid;
   logic [1:0]     top_ch;
   logic           escalate;

   int n_vec = 0;
   int n_err = 0;

   alarm_controller #(
      .NUM_CH     (NCH),
      .DEBOUNCE   (DEB),
      .ESC_CYCLES (ESC)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .sensor    (sensor),
      .arm       (arm),
      .ack       (ack),
      .alarm     (alarm),
      .any_alarm (any_alarm),
      .top_valid (top_valid),
      .top_ch    (top_ch),
      .escalate  (escalate)
   );

   always #5 clk = ~clk;

   // Behavioural model: an alarm fires once DEB consecutive high samples are
   // seen while armed and not silenced; an ack silences a still-present
   // condition until the sensor drops; unack counts edges an alarm stays up.
   logic [NCH-1:0] m_alarm = '0;
   logic [NCH-1:0] m_silenced = '0;
   int             m_streak [NCH];
   int             m_unack [NCH];

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_alarm    <= '0;
         m_silenced <= '0;
         for (int i = 0; i < NCH; i++) begin
            m_streak[i] <= 0;
            m_unack[i]  <= 0;
         end
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (!arm[i]) begin
               m_alarm[i]    <= 1'b0;
               m_silenced[i] <= 1'b0;
               m_streak[i]   <= 0;
               m_unack[i]    <= 0;
            end else if (m_alarm[i]) begin
               if (ack[i]) begin
                  m_alarm[i]    <= 1'b0;
                  m_silenced[i] <= sensor[i];
                  m_unack[i]    <= 0;
               end else if (m_unack[i] < ESC) begin
                  m_unack[i] <= m_unack[i] + 1;
               end
            end else if (m_silenced[i]) begin
               if (!sensor[i]) m_silenced[i] <= 1'b0;
            end else if (sensor[i]) begin
               if (m_streak[i] + 1 >= DEB) begin
                  m_alarm[i]  <= 1'b1;
                  m_streak[i] <= 0;
                  m_unack[i]  <= 0;
               end else begin
                  m_streak[i] <= m_streak[i] + 1;
               end
            end else begin
               m_streak[i] <= 0;
            end
         end
      end
   end

   function automatic int exp_top(input logic [NCH-1:0] a);
      for (int i = 0; i < NCH; i++) begin
         if (a[i]) return i;
      end
      return 0;
   endfunction

   function automatic logic exp_esc();
      logic e = 1'b0;
`ifdef ALARM_ESCALATE_EN
      for (int i = 0; i < NCH; i++) begin
         if (m_alarm[i] && m_unack[i] >= ESC) e = 1'b1;
      end
`endif
      return e;
   endfunction

   task automatic check(input string name, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
      end
   endtask

   // Cycle-by-cycle comparison against the model, away from the rising edge.
   logic done = 1'b0;
   always @(negedge clk) begin
      if (!done) begin
         check("alarm", int'(alarm), int'(m_alarm));
         check("any_alarm", int'(any_alarm), int'(|m_alarm));
         check("top_valid", int'(top_valid), int'(|m_alarm));
         check("top_ch", int'(top_ch), exp_top(m_alarm));
         check("escalate", int'(escalate), int'(exp_esc()));
      end
   end

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_ack(input logic [NCH-1:0] a);
      ack = a;
      wait_neg(1);
      ack = '0;
   endtask

   initial begin
      #1 reset = 1'b0;
      wait_neg(3);
      check("lit_reset_alarm", int'(alarm), 0);
      reset = 1'b1;
      wait_neg(10);
      check("lit_idle_alarm", int'(alarm), 0);
      $display("reset and 10 idle cycles done");

      // Debounce of exactly DEB samples.
      sensor = 3'b001;
      wait_neg(3);
      check("lit_deb3_alarm", int'(alarm), 0);
      wait_neg(1);
      check("lit_deb4_alarm", int'(alarm), 1);
      check("lit_deb4_top", int'(top_ch), 0);
      check("lit_deb4_any", int'(any_alarm), 1);
      sensor = 3'b000;
      pulse_ack(3'b001);
      check("lit_ack0_alarm", int'(alarm), 0);
      $display("txn: ch0 debounce + ack");

      // Short pulse aborts on the last count cycle.
      sensor = 3'b001;
      wait_neg(3);
      sensor = 3'b000;
      wait_neg(5);
      check("lit_short_alarm", int'(alarm), 0);
      $display("txn: 3-cycle pulse rejected");

      // Two channels, ack silences one while the condition persists.
      sensor = 3'b110;
      wait_neg(4);
      check("lit_110_alarm", int'(alarm), 3'b110);
      check("lit_110_top", int'(top_ch), 1);
      pulse_ack(3'b010);
      check("lit_ack1_alarm", int'(alarm), 3'b100);
      check("lit_ack1_top", int'(top_ch), 2);
      wait_neg(3);
      check("lit_silenced_alarm", int'(alarm), 3'b100);
      sensor = 3'b100;
      wait_neg(2);
      sensor = 3'b110;
      wait_neg(4);
      check("lit_rearm_alarm", int'(alarm), 3'b110);
      sensor = 3'b000;
      pulse_ack(3'b110);
      check("lit_clear_alarm", int'(alarm), 0);
      $display("txn: ch1/ch2 ack and re-trigger");

      // Latched alarm survives a sensor drop until acked.
      sensor = 3'b100;
      wait_neg(4);
      sensor = 3'b000;
      wait_neg(50);
      check("lit_latched_alarm", int'(alarm), 3'b100);
      pulse_ack(3'b100);
      check("lit_latch_ack_alarm", int'(alarm), 0);
      $display("txn: ch2 latched 50 cycles");

      // Disarm dominates a same-cycle ack; disarmed channel cannot rise.
      sensor = 3'b001;
      wait_neg(4);
      check("lit_ch0_alarm", int'(alarm), 3'b001);
      arm = 3'b110;
      pulse_ack(3'b001);
      check("lit_disarm_alarm", int'(alarm), 0);
      wait_neg(10);
      check("lit_disarmed_alarm", int'(alarm), 0);
      arm = 3'b111;
      wait_neg(4);
      check("lit_rearmed_alarm", int'(alarm), 3'b001);
      sensor = 3'b000;
      pulse_ack(3'b001);
      $display("txn: disarm vs ack");

      // Escalation after ESC edges in ACTIVE, cleared by ack.
      sensor = 3'b010;
      wait_neg(4);
      wait_neg(ESC - 1);
      check("lit_esc_before", int'(escalate), 0);
      wait_neg(1);
`ifdef ALARM_ESCALATE_EN
      check("lit_esc_at", int'(escalate), 1);
`else
      check("lit_esc_at", int'(escalate), 0);
`endif
      pulse_ack(3'b010);
      check("lit_esc_cleared", int'(escalate), 0);
      sensor = 3'b000;
      wait_neg(2);
      $display("txn: escalation on ch1");

      // Asynchronous reset mid-alarm and mid-debounce.
      sensor = 3'b100;
      wait_neg(4);
      sensor = 3'b101;
      wait_neg(2);
      #2 reset = 1'b0;
      #1;
      check("lit_async_alarm", int'(alarm), 0);
      check("lit_async_valid", int'(top_valid), 0);
      check("lit_async_any", int'(any_alarm), 0);
      check("lit_async_esc", int'(escalate), 0);
      wait_neg(2);
      reset = 1'b1;
      sensor = 3'b000;
      wait_neg(3);
      $display("txn: async reset");

      done = 1'b1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
